// File: rtl/card_dealer.sv
// Card source for the bell game: deals LFSR-derived cards alternately to two slots
// and runs the reaction countdown that the scorer awards as points.
module card_dealer #(
  parameter int          FLIP_PERIOD = 50,
  parameter int          TICK_DIV    = 4,
  parameter logic [7:0]  COUNT_INIT  = 8'd100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       finish,
  output logic [1:0] c1,
  output logic [2:0] n1,
  output logic [1:0] c2,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       flip,
  output logic       turn
);

  localparam int PER_W  = $clog2(FLIP_PERIOD);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(FLIP_PERIOD - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FROZEN = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [PER_W-1:0]  per_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              zero_all;
  logic              advance;
  logic              flip_event;
  logic              tick_wrap;
  logic [1:0]        card_colour;
  logic [2:0]        card_value;
  logic [2:0]        card_number;

  assign lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign card_colour = lfsr[1:0];
  assign card_value  = lfsr[4:2];
  // Values 5..7 fold back onto 1..3 so a dealt card is never blank.
  assign card_number = (card_value < 3'd5) ? (card_value + 3'd1) : (card_value - 3'd4);
  assign flip_event  = advance && (per_cnt == PER_LAST);
  assign tick_wrap   = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // zero_all drives the table and counters to their idle values; advance lets PLAY run.
  always_comb begin
    state_next = state;
    zero_all   = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        zero_all = 1'b1;
        if (start && !stop) state_next = PLAY;
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
          zero_all   = 1'b1;
        end else if (finish) begin
          state_next = FROZEN;
        end else begin
          advance = 1'b1;
        end
      end
      FROZEN: begin
        if (stop) begin
          state_next = IDLE;
          zero_all   = 1'b1;
        end else if (!finish) begin
          state_next = CLEAR;
          zero_all   = 1'b1;
        end
      end
      CLEAR: begin
        zero_all   = 1'b1;
        state_next = stop ? IDLE : PLAY;
      end
      default: begin
        state_next = IDLE;
        zero_all   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= lfsr_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1       <= 2'd0;
      n1       <= 3'd0;
      c2       <= 2'd0;
      n2       <= 3'd0;
      count    <= 8'd0;
      flip     <= 1'b0;
      turn     <= 1'b0;
      per_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      flip <= flip_event;
      if (zero_all) begin
        c1       <= 2'd0;
        n1       <= 3'd0;
        c2       <= 2'd0;
        n2       <= 3'd0;
        count    <= 8'd0;
        turn     <= 1'b0;
        per_cnt  <= '0;
        tick_cnt <= '0;
      end else if (flip_event) begin
        if (!turn) begin
          c1 <= card_colour;
          n1 <= card_number;
        end else begin
          c2 <= card_colour;
          n2 <= card_number;
        end
        turn     <= ~turn;
        count    <= COUNT_INIT;
        per_cnt  <= '0;
        tick_cnt <= '0;
      end else if (advance) begin
        per_cnt  <= per_cnt + PER_W'(1);
        tick_cnt <= tick_wrap ? '0 : (tick_cnt + TICK_W'(1));
        // Count only falls once a card is out and never below 1, so a correct ring always scores.
        if (tick_wrap && (count > 8'd1)) count <= count - 8'd1;
      end
    end
  end

endmodule
